// File: rtl/flit_fifo_buffer.sv
// Router input-port flit FIFO, valid/ready on both sides, head flit read combinationally.
// Optional registered almost_full watermark enabled by defining FIFO_ALMOST_FULL_EN.
module flit_fifo_buffer #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push;
  logic                  pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + 1'b1;
    else if (pop && !push)
      count_next = count_q - 1'b1;
  end

  // Pointers wrap through natural ADDR_WIDTH overflow; a full FIFO refuses pushes,
  // so a simultaneous write never lands on the entry being read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      almost_full <= 1'b0;
    else
      almost_full <= (count_next >= AF_CNT);
  end
`else
  logic unused_af_thresh;
  assign unused_af_thresh = ^AF_THRESH;
  assign almost_full      = 1'b0;
`endif

endmodule

// File: tb/tb_flit_fifo_buffer.sv
// Scoreboard bench for flit_fifo_buffer: a queue model tracks expected contents,
// a negedge monitor compares every DUT output against it.
module tb_flit_fifo_buffer;
  localparam int WIDTH = 18;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [AW:0]      count;
  logic             almost_full;

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] exp_q [$];

  flit_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of flits, decisions taken from the occupancy before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      automatic bit do_pop  = out_ready && (exp_q.size() > 0);
      automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    automatic int sz = exp_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("out_data", 32'(out_data), (sz != 0) ? 32'(exp_q[0]) : 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
`else
    chk("almost_full", 32'(almost_full), 32'd0);
`endif
  end

  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream with no clock edge in between
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'h100 + i), 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Fill to FULL, then a refused ninth flit
    for (int i = 1; i <= 8; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 18'h3FFFF, 1'b0);
    chk("ninth_refused", 32'(count), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(out_data), 32'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Wrap-around
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(32'h200 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(32'h300 + i), 1'b0);
    chk("wrap_count", 32'(count), 32'd6);
    chk("wrap_head", 32'(out_data), 32'h300);

    // PARTIAL push+pop at count 3
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 18'h0ABCD, 1'b1);
    chk("partial_pushpop", 32'(count), 32'd3);

    // FULL with pop plus push: push refused
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(32'h400 + i), 1'b0);
    chk("full_again", 32'(count), 32'd8);
    cycle(1'b1, 18'h2AAAA, 1'b1);
    chk("full_pushpop", 32'(count), 32'd7);
    chk("full_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);

    // EMPTY with push and out_ready: no bypass
    cycle(1'b1, 18'h15555, 1'b1);
    chk("empty_pushpop", 32'(count), 32'd1);
    chk("empty_head", 32'(out_data), 32'h15555);
    cycle(1'b0, '0, 1'b1);

    // Watermark sweep: up to 6, down to 5
    for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(32'h500 + i), 1'b0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("af_rise", 32'(almost_full), 32'd1);
`else
    chk("af_off_high", 32'(almost_full), 32'd0);
`endif
    cycle(1'b0, '0, 1'b1);
    chk("af_fall", 32'(almost_full), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Randomized traffic, with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      automatic int phase = (i / 300) % 3;
      automatic logic iv = (phase == 0) ? ($urandom_range(0, 9) < 8) :
                           (phase == 1) ? ($urandom_range(0, 9) < 2) : 1'($urandom);
      automatic logic ordy = (phase == 0) ? ($urandom_range(0, 9) < 2) :
                             (phase == 1) ? ($urandom_range(0, 9) < 8) : 1'($urandom);
      cycle(iv, WIDTH'($urandom), ordy);
    end

    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
